multi_zone_alarm_ctrl: RTL and testbench

MULTI_ZONE_ALARM_CTRL -- requirements
Module: multi_zone_alarm_ctrl

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_tick_gen.sv | 35 +++
 rtl/multi_zone_alarm_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multi_zone_alarm_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alarm_pkg                                                  |
// | Shared state encodings and field widths for the zone alarm block.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package alarm_pkg;

  // Width of a zone index (supports up to 16 zones)
  localparam int c_zone_idx_w = 4;
  // Width of the saturating alarm counter
  localparam int c_alarm_cnt_w = 8;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMING   = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alarm_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alarm_tick_gen                                             |
// | Free-running divider; one-cycle tick every TICK_DIV clk cycles.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alarm_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_wrap;

  assign w_wrap = (r_cnt == c_cnt_w'(TICK_DIV - 1));
  assign tick   = w_wrap;

  // Count 0..TICK_DIV-1 and wrap; the tick marks the last count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_zone_alarm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multi_zone_alarm_ctrl                                      |
// | Multi-zone vehicle alarm: arming delay, per-zone entry delay, siren  |
// | with re-trigger. Optional logging enabled by macro ALARM_LOG_EN.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module multi_zone_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int CNT_W     = 6,
  parameter int TICK_DIV  = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ign,
  input  logic [NUM_ZONES-1:0]       zone_trip,
  input  logic [CNT_W-1:0]           arm_dly,
  input  logic [NUM_ZONES*CNT_W-1:0] entry_dly,
  input  logic [CNT_W-1:0]           alarm_dly,
  output logic                       siren,
  output logic                       status,
  output logic [2:0]                 state_o,
  output logic [c_zone_idx_w-1:0]    first_zone,
  output logic [c_alarm_cnt_w-1:0]   alarm_count
);

  logic                 r_ign_s1, r_ign_s2;
  logic [NUM_ZONES-1:0] r_zone_s1, r_zone_s2;
  logic                 w_tick;
  logic                 w_any_open;
  logic [CNT_W-1:0]     w_low_dly;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cd, w_cd_nxt;
  logic             r_siren, r_status, w_status_nxt;

  alarm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Two-flop synchronizers for the asynchronous ignition and zone inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ign_s1  <= 1'b0;
      r_ign_s2  <= 1'b0;
      r_zone_s1 <= '0;
      r_zone_s2 <= '0;
    end else begin
      r_ign_s1  <= ign;
      r_ign_s2  <= r_ign_s1;
      r_zone_s1 <= zone_trip;
      r_zone_s2 <= r_zone_s1;
    end
  end

  assign w_any_open = |r_zone_s2;

  // Entry delay of the lowest-index open zone (scan high to low, last hit wins)
  always_comb begin
    w_low_dly = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (r_zone_s2[i]) begin
        w_low_dly = entry_dly[i*CNT_W +: CNT_W];
      end
    end
  end

  // State, countdown and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_DISARMED;
      r_cd     <= '0;
      r_siren  <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cd     <= w_cd_nxt;
      r_siren  <= (w_state_nxt == S_ALARM);
      r_status <= w_status_nxt;
    end
  end

  // Next-state and countdown; ignition overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    if (r_ign_s2) begin
      w_state_nxt = S_DISARMED;
      w_cd_nxt    = '0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (!w_any_open) begin
            w_state_nxt = S_ARMING;
            w_cd_nxt    = arm_dly;
          end
        end
        S_ARMING: begin
          if (w_any_open) begin
            w_cd_nxt = arm_dly;
          end else if (w_tick) begin
            if (r_cd == '0) w_state_nxt = S_ARMED;
            else            w_cd_nxt    = r_cd - CNT_W'(1);
          end
        end
        S_ARMED: begin
          if (w_any_open) begin
            w_state_nxt = S_ENTRY;
            w_cd_nxt    = w_low_dly;
          end
        end
        S_ENTRY: begin
          if (w_tick) begin
            if (r_cd == '0) begin
              w_state_nxt = S_ALARM;
              w_cd_nxt    = alarm_dly;
            end else begin
              w_cd_nxt = r_cd - CNT_W'(1);
            end
          end
        end
        S_ALARM: begin
          if (w_tick) begin
            if (r_cd == '0) begin
              if (!w_any_open) w_state_nxt = S_ARMED;
              else             w_cd_nxt    = alarm_dly;
            end else begin
              w_cd_nxt = r_cd - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_DISARMED;
          w_cd_nxt    = '0;
        end
      endcase
    end
  end

  // Status LED: off when disarmed, blinking per tick while armed, else on
  always_comb begin
    w_status_nxt = 1'b1;
    case (w_state_nxt)
      S_DISARMED: w_status_nxt = 1'b0;
      S_ARMED:    w_status_nxt = (r_state == S_ARMED) ? (r_status ^ w_tick) : 1'b1;
      default:    w_status_nxt = 1'b1;
    endcase
  end

  assign siren   = r_siren;
  assign status  = r_status;
  assign state_o = r_state;

`ifdef ALARM_LOG_EN
  logic [c_zone_idx_w-1:0]  w_low_idx;
  logic [c_zone_idx_w-1:0]  r_zone_idx;
  logic [c_zone_idx_w-1:0]  r_first_zone;
  logic [c_alarm_cnt_w-1:0] r_alarm_count;
  logic                     w_alarm_enter;

  // Index of the lowest-index open zone
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (r_zone_s2[i]) begin
        w_low_idx = c_zone_idx_w'(i);
      end
    end
  end

  // Entering ALARM from elsewhere, or re-triggering while already in it
  assign w_alarm_enter = (w_state_nxt == S_ALARM) &&
                         ((r_state != S_ALARM) || (w_tick && (r_cd == '0)));

  // Capture triggering zone and maintain the saturating alarm counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zone_idx    <= '0;
      r_first_zone  <= '0;
      r_alarm_count <= '0;
    end else begin
      if (r_state == S_ARMED && w_state_nxt == S_ENTRY) begin
        r_zone_idx <= w_low_idx;
      end
      if (r_state == S_ENTRY && w_state_nxt == S_ALARM) begin
        r_first_zone <= r_zone_idx;
      end
      if (w_alarm_enter && (r_alarm_count != '1)) begin
        r_alarm_count <= r_alarm_count + c_alarm_cnt_w'(1);
      end
    end
  end

  assign first_zone  = r_first_zone;
  assign alarm_count = r_alarm_count;
`else
  assign first_zone  = '0;
  assign alarm_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_zone_alarm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_multi_zone_alarm_ctrl                                   |
// | Self-checking bench: directed vector table, hand sequences and       |
// | randomized traffic against a behavioural reference model.            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_multi_zone_alarm_ctrl;

  localparam int NZ = 4;
  localparam int CW = 4;
  localparam int TD = 4;
`ifdef ALARM_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  localparam int DIS = 0, ARMING = 1, ARMED = 2, ENTRY = 3, ALARM = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ign = 1'b0;
  logic [NZ-1:0]    zone_trip = '0;
  logic [CW-1:0]    arm_dly = '0;
  logic [NZ*CW-1:0] entry_dly = '0;
  logic [CW-1:0]    alarm_dly = '0;
  logic             siren, status;
  logic [2:0]       state_o;
  logic [3:0]       first_zone;
  logic [7:0]       alarm_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_zone_alarm_ctrl #(.NUM_ZONES(NZ), .CNT_W(CW), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .ign         (ign),
    .zone_trip   (zone_trip),
    .arm_dly     (arm_dly),
    .entry_dly   (entry_dly),
    .alarm_dly   (alarm_dly),
    .siren       (siren),
    .status      (status),
    .state_o     (state_o),
    .first_zone  (first_zone),
    .alarm_count (alarm_count)
  );

  // ---------------- behavioural reference model ----------------
  int            m_st, m_cd, m_phase, m_idx, m_fz, m_cnt, m_prev;
  bit            m_sir, m_sta, m_tick, m_ign_e;
  bit            ign_hist [2];
  logic [NZ-1:0] zone_hist [2];
  logic [NZ-1:0] m_z_e;
  bit            m_found;

  // Inputs are seen two edges late; one tick every TD cycles after reset
  always @(posedge clk) begin
    if (reset) begin
      m_st = DIS; m_cd = 0; m_phase = 0; m_idx = 0; m_fz = 0; m_cnt = 0;
      m_sir = 0; m_sta = 0;
      ign_hist[0] = 0; ign_hist[1] = 0; zone_hist[0] = '0; zone_hist[1] = '0;
    end else begin
      m_ign_e = ign_hist[1];
      m_z_e   = zone_hist[1];
      m_tick  = (m_phase == TD - 1);
      m_phase = (m_phase + 1) % TD;
      m_prev  = m_st;
      if (m_ign_e) begin
        m_st = DIS; m_cd = 0;
      end else if (m_st == DIS) begin
        if (m_z_e == 0) begin m_st = ARMING; m_cd = arm_dly; end
      end else if (m_st == ARMING) begin
        if (m_z_e != 0) m_cd = arm_dly;
        else if (m_tick) begin
          if (m_cd == 0) m_st = ARMED; else m_cd = m_cd - 1;
        end
      end else if (m_st == ARMED) begin
        if (m_z_e != 0) begin
          m_found = 0;
          for (int i = 0; i < NZ; i++) begin
            if (m_z_e[i] && !m_found) begin m_idx = i; m_found = 1; end
          end
          m_cd = int'((entry_dly >> (m_idx * CW)) & 16'hF);
          m_st = ENTRY;
        end
      end else if (m_st == ENTRY) begin
        if (m_tick) begin
          if (m_cd == 0) begin
            m_st = ALARM; m_cd = alarm_dly; m_fz = m_idx;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
          end else m_cd = m_cd - 1;
        end
      end else begin
        if (m_tick) begin
          if (m_cd == 0) begin
            if (m_z_e == 0) m_st = ARMED;
            else begin
              m_cd = alarm_dly;
              if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
          end else m_cd = m_cd - 1;
        end
      end
      m_sir = (m_st == ALARM);
      if (m_st == DIS) m_sta = 0;
      else if (m_st == ARMED) m_sta = (m_prev == ARMED) ? (m_sta ^ m_tick) : 1'b1;
      else m_sta = 1;
      ign_hist[1]  = ign_hist[0];  ign_hist[0]  = ign;
      zone_hist[1] = zone_hist[0]; zone_hist[0] = zone_trip;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int want, input int budget, input string name);
    int k;
    k = 0;
    while (int'(state_o) != want && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(state_o), want);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] zones;
    int         ncyc;
    int         st;
    int         sir;
    int         sta;
    int         fz;
    int         cnt;
  } vec_t;

  vec_t tbl [18];
  logic [16:0] act_v, exp_v;

  initial begin
    // zone0=5, zone1=7, zone2=3, zone3=9
    tbl[0]  = '{4'h0,  0, DIS,    0, 0, 0, 0};
    tbl[1]  = '{4'h0,  1, ARMING, 0, 1, 0, 0};
    tbl[2]  = '{4'h0, 10, ARMING, 0, 1, 0, 0};
    tbl[3]  = '{4'h0,  1, ARMED,  0, 1, 0, 0};
    tbl[4]  = '{4'h0,  3, ARMED,  0, 1, 0, 0};
    tbl[5]  = '{4'h0,  1, ARMED,  0, 0, 0, 0};
    tbl[6]  = '{4'h0,  4, ARMED,  0, 1, 0, 0};
    tbl[7]  = '{4'h4,  2, ARMED,  0, 1, 0, 0};
    tbl[8]  = '{4'h4,  1, ENTRY,  0, 1, 0, 0};
    tbl[9]  = '{4'h4, 12, ENTRY,  0, 1, 0, 0};
    tbl[10] = '{4'h4,  1, ALARM,  1, 1, 2, 1};
    tbl[11] = '{4'h4,  7, ALARM,  1, 1, 2, 1};
    tbl[12] = '{4'h4,  1, ALARM,  1, 1, 2, 2};
    tbl[13] = '{4'h0,  7, ALARM,  1, 1, 2, 2};
    tbl[14] = '{4'h0,  1, ARMED,  0, 1, 2, 2};
    tbl[15] = '{4'hA,  3, ENTRY,  0, 1, 2, 2};
    tbl[16] = '{4'hA, 28, ENTRY,  0, 1, 2, 2};
    tbl[17] = '{4'hA,  1, ALARM,  1, 1, 1, 3};

    arm_dly   = 4'd2;
    entry_dly = 16'h9375;
    alarm_dly = 4'd1;
    @(negedge clk);
    do_reset();

    // Directed table: arming, entry, alarm, re-trigger, priority select
    for (int r = 0; r < 18; r++) begin
      zone_trip = tbl[r].zones;
      repeat (tbl[r].ncyc) @(negedge clk);
      check($sformatf("row%0d.state", r), int'(state_o), tbl[r].st);
      check($sformatf("row%0d.siren", r), int'(siren), tbl[r].sir);
      check($sformatf("row%0d.status", r), int'(status), tbl[r].sta);
      check($sformatf("row%0d.first_zone", r), int'(first_zone), LOG ? tbl[r].fz : 0);
      check($sformatf("row%0d.alarm_count", r), int'(alarm_count), LOG ? tbl[r].cnt : 0);
    end

    // Reset pulsed during ALARM clears everything on the next edge
    reset = 1'b1;
    @(negedge clk);
    check("rst_alarm.siren", int'(siren), 0);
    check("rst_alarm.state", int'(state_o), DIS);
    check("rst_alarm.count", int'(alarm_count), 0);
    check("rst_alarm.status", int'(status), 0);
    check("rst_alarm.first_zone", int'(first_zone), 0);

    // Ignition during ENTRY disarms three cycles later, siren never asserts
    zone_trip = '0;
    arm_dly   = 4'd0;
    entry_dly = 16'h9999;
    @(negedge clk);
    reset = 1'b0;
    wait_state(ARMED, 100, "ign_seq.armed");
    zone_trip = 4'h2;
    wait_state(ENTRY, 20, "ign_seq.entry");
    check("ign_seq.siren_entry", int'(siren), 0);
    ign = 1'b1;
    @(negedge clk);
    check("ign_seq.st_c1", int'(state_o), ENTRY);
    @(negedge clk);
    check("ign_seq.st_c2", int'(state_o), ENTRY);
    check("ign_seq.siren_c2", int'(siren), 0);
    @(negedge clk);
    check("ign_seq.st_c3", int'(state_o), DIS);
    check("ign_seq.siren_c3", int'(siren), 0);
    check("ign_seq.status_c3", int'(status), 0);
    ign = 1'b0;
    zone_trip = '0;

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      act_v = {state_o, siren, status, first_zone, alarm_count};
      exp_v = {3'(m_st), m_sir, m_sta,
               LOG ? 4'(m_fz) : 4'd0, LOG ? 8'(m_cnt) : 8'd0};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL rand_cyc%0d: got %h required %h", c, act_v, exp_v);
      end
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 7) == 0)
        zone_trip = ($urandom_range(0, 2) == 0) ? NZ'($urandom) : '0;
      if (!ign && $urandom_range(0, 299) == 0) ign = 1'b1;
      else if (ign && $urandom_range(0, 19) == 0) ign = 1'b0;
      if ($urandom_range(0, 31) == 0) begin
        arm_dly   = CW'($urandom_range(0, 3));
        alarm_dly = CW'($urandom_range(0, 3));
        entry_dly = (NZ*CW)'($urandom);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
